// File: rtl/adc_averager_pkg.sv
// adc_averager_pkg
//   Shared definitions for the ADC averager: FSM state encoding, channel
//   count, sample width and a helper for sizing the sample counter.
//   No ports (package).
`ifndef ADC_AVERAGER_PKG_SV
`define ADC_AVERAGER_PKG_SV

package adc_averager_pkg;

    localparam int NUM_CH   = 4;
    localparam int SAMPLE_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // The sample counter is LOG2N bits wide; with LOG2N=0 it degenerates to a
    // single bit that never leaves 0, so every sample completes a window.
    function automatic int cnt_width(input int log2n);
        return (log2n > 0) ? log2n : 1;
    endfunction

endpackage

`endif

// File: rtl/adc_acc_lane.sv
// adc_acc_lane
//   One per-channel accumulator register. The adder itself is shared and
//   lives in the parent; this lane only captures the shared sum when its
//   add enable is high, or clears.
// Ports:
//   clk    - system clock
//   _rst   - asynchronous active-low reset
//   clr    - synchronous clear (takes priority over add_en)
//   add_en - load the shared adder result this cycle
//   sum    - shared adder result (this lane's acc + its snapshot)
//   acc    - current accumulator value
module adc_acc_lane #(
    parameter int ACC_W = 15
) (
    input  logic             clk,
    input  logic             _rst,
    input  logic             clr,
    input  logic             add_en,
    input  logic [ACC_W-1:0] sum,
    output logic [ACC_W-1:0] acc
);

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (add_en) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/adc_averager.sv
// adc_averager
//   Averages 2^LOG2N four-channel ADC conversions. Each rising edge of
//   data_ready snapshots ch0..ch3; the FSM then spends four cycles folding
//   the snapshot into per-channel accumulators through one shared adder.
//   After the last sample of a window, DONE loads the truncated averages
//   and clears the accumulators; avg_valid strobes the following cycle.
// Ports:
//   clk        - system clock, rising edge
//   _rst       - asynchronous active-low reset
//   data_ready - conversion complete (pulse or level; rising edge is used)
//   ch0..ch3   - 12-bit unsigned conversion results
//   clr_ovr    - synchronous clear of overrun (a same-cycle drop wins)
//   avg0..avg3 - registered averages, held between strobes
//   avg_valid  - one-cycle strobe for new avg0..avg3
//   busy       - high in ACC and DONE
//   overrun    - sticky: a sample edge arrived while busy and was dropped
//   fsm_state  - current FSM state for observation
module adc_averager
    import adc_averager_pkg::*;
#(
    parameter int LOG2N = 3
) (
    input  logic        clk,
    input  logic        _rst,
    input  logic        data_ready,
    input  logic [11:0] ch0,
    input  logic [11:0] ch1,
    input  logic [11:0] ch2,
    input  logic [11:0] ch3,
    input  logic        clr_ovr,
    output logic [11:0] avg0,
    output logic [11:0] avg1,
    output logic [11:0] avg2,
    output logic [11:0] avg3,
    output logic        avg_valid,
    output logic        busy,
    output logic        overrun,
    output logic [1:0]  fsm_state
);

    // Accumulator width covers 2^LOG2N * 4095 without overflow.
    localparam int ACC_W = SAMPLE_W + LOG2N;
    localparam int CNT_W = cnt_width(LOG2N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2N) - 1);

    state_t state, state_nxt;

    logic [1:0]          phase;      // channel being added while in ACC
    logic [CNT_W-1:0]    cnt;        // samples accepted in current window
    logic                dr_prev;
    logic                armed;      // low for the first cycle after reset
    logic                sample_event;

    logic [SAMPLE_W-1:0] ch_arr  [NUM_CH];
    logic [SAMPLE_W-1:0] snap    [NUM_CH];
    logic [ACC_W-1:0]    acc     [NUM_CH];
    logic [SAMPLE_W-1:0] avg_r   [NUM_CH];

    logic [NUM_CH-1:0]   add_en;
    logic                acc_clr;
    logic                take_snap;
    logic                load_avg;
    logic                acc_end;
    logic [ACC_W-1:0]    sum;

    assign ch_arr[0] = ch0;
    assign ch_arr[1] = ch1;
    assign ch_arr[2] = ch2;
    assign ch_arr[3] = ch3;

    // A sample event is a 0->1 transition of data_ready. The armed flag keeps
    // a level that is already high at reset release from counting, since the
    // history register comes out of reset as 0.
    assign sample_event = data_ready & ~dr_prev & armed;

    assign acc_end = (state == ST_ACC) && (phase == 2'd3);

    // Shared adder: the operand mux picks the accumulator and snapshot of the
    // channel selected by phase.
    assign sum = acc[phase] + ACC_W'(snap[phase]);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next state and controls ----------------
    always_comb begin
        state_nxt = state;
        add_en    = '0;
        acc_clr   = 1'b0;
        take_snap = 1'b0;
        load_avg  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sample_event) begin
                    take_snap = 1'b1;
                    state_nxt = ST_ACC;
                end
            end
            ST_ACC: begin
                add_en[phase] = 1'b1;
                if (phase == 2'd3) begin
                    state_nxt = (cnt == CNT_LAST) ? ST_DONE : ST_IDLE;
                end
            end
            ST_DONE: begin
                load_avg  = 1'b1;
                acc_clr   = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ---------------- edge detect, phase, sample counter ----------------
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            dr_prev <= 1'b0;
            armed   <= 1'b0;
            phase   <= 2'd0;
            cnt     <= '0;
        end else begin
            dr_prev <= data_ready;
            armed   <= 1'b1;
            phase   <= (state == ST_ACC) ? phase + 2'd1 : 2'd0;
            if (acc_end) begin
                cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
            end
        end
    end

    // ---------------- snapshots and averages ----------------
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                snap[i]  <= '0;
                avg_r[i] <= '0;
            end
            avg_valid <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (take_snap) begin
                    snap[i] <= ch_arr[i];
                end
                if (load_avg) begin
                    avg_r[i] <= SAMPLE_W'(acc[i] >> LOG2N);
                end
            end
            avg_valid <= load_avg;
        end
    end

    // ---------------- overrun: set beats clear ----------------
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            overrun <= 1'b0;
        end else if (sample_event && (state != ST_IDLE)) begin
            overrun <= 1'b1;
        end else if (clr_ovr) begin
            overrun <= 1'b0;
        end
    end

    // ---------------- accumulator lanes ----------------
    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        adc_acc_lane #(
            .ACC_W (ACC_W)
        ) u_lane (
            .clk    (clk),
            ._rst   (_rst),
            .clr    (acc_clr),
            .add_en (add_en[g]),
            .sum    (sum),
            .acc    (acc[g])
        );
    end

    assign avg0      = avg_r[0];
    assign avg1      = avg_r[1];
    assign avg2      = avg_r[2];
    assign avg3      = avg_r[3];
    assign busy      = (state != ST_IDLE);
    assign fsm_state = state;

endmodule

// File: tb/tb_adc_averager.sv
// tb_adc_averager
//   Three averagers (LOG2N = 0, 2, 3) share one stimulus stream. A
//   window-level reference model predicts, per instance, which edges are
//   accepted, when each window completes, the averages, busy and overrun.
module tb_adc_averager;
    import adc_averager_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        _rst;
    logic        data_ready;
    logic        clr_ovr;
    logic [11:0] ch [4];

    logic [3:0][11:0] avg_o  [3];
    logic             avg_v  [3];
    logic             busy_o [3];
    logic             ovr_o  [3];
    logic [1:0]       st_o   [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        adc_averager #(
            .LOG2N (g == 0 ? 0 : (g == 1 ? 2 : 3))
        ) u_dut (
            .clk        (clk),
            ._rst       (_rst),
            .data_ready (data_ready),
            .ch0        (ch[0]),
            .ch1        (ch[1]),
            .ch2        (ch[2]),
            .ch3        (ch[3]),
            .clr_ovr    (clr_ovr),
            .avg0       (avg_o[g][0]),
            .avg1       (avg_o[g][1]),
            .avg2       (avg_o[g][2]),
            .avg3       (avg_o[g][3]),
            .avg_valid  (avg_v[g]),
            .busy       (busy_o[g]),
            .overrun    (ovr_o[g]),
            .fsm_state  (st_o[g])
        );
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Window view: an accepted edge at cycle T occupies the block until T+5,
    // or T+6 when it completes a window (avg_valid in T+6). Edges before that
    // are dropped and set overrun.
    int          lg [3] = '{0, 2, 3};
    longint      cyc = 0;
    longint      free_at   [3];
    longint      busy_from [3];
    longint      valid_at  [3];
    int          cnt_m     [3];
    int          sum_m     [3][4];
    logic [11:0] pend      [3][4];
    logic [11:0] exp_avg   [3][4];
    logic        exp_ovr   [3];
    logic        m_prev, m_armed;
    int          vcount    [3] = '{0, 0, 0};

    task automatic model_clear(input int k);
        free_at[k]   = 0;
        busy_from[k] = 0;
        valid_at[k]  = -1;
        cnt_m[k]     = 0;
        exp_ovr[k]   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sum_m[k][i]   = 0;
            pend[k][i]    = '0;
            exp_avg[k][i] = '0;
        end
    endtask

    always @(posedge clk) begin
        if (!_rst) begin
            m_prev  = 1'b0;
            m_armed = 1'b0;
            for (int k = 0; k < 3; k++) model_clear(k);
        end else begin
            logic ev;
            ev      = data_ready && !m_prev && m_armed;
            m_prev  = data_ready;
            m_armed = 1'b1;
            for (int k = 0; k < 3; k++) begin
                if (ev && cyc < free_at[k]) begin
                    exp_ovr[k] = 1'b1;
                end else begin
                    if (clr_ovr) exp_ovr[k] = 1'b0;
                    if (ev) begin
                        for (int i = 0; i < 4; i++) sum_m[k][i] += int'(ch[i]);
                        cnt_m[k]++;
                        busy_from[k] = cyc + 1;
                        if (cnt_m[k] == (1 << lg[k])) begin
                            for (int i = 0; i < 4; i++) begin
                                pend[k][i]  = 12'(sum_m[k][i] / (1 << lg[k]));
                                sum_m[k][i] = 0;
                            end
                            cnt_m[k]    = 0;
                            valid_at[k] = cyc + 6;
                            free_at[k]  = cyc + 6;
                        end else begin
                            free_at[k] = cyc + 5;
                        end
                    end
                end
            end
        end
        cyc++;
    end

    // ---------------- scoreboard: every cycle, away from the edge ----------------
    always @(negedge clk) begin
        if (_rst === 1'b1) begin
            for (int k = 0; k < 3; k++) begin
                if (cyc == valid_at[k]) begin
                    for (int i = 0; i < 4; i++) exp_avg[k][i] = pend[k][i];
                end
                if (avg_v[k] === 1'b1) vcount[k]++;
                check($sformatf("n%0d_valid", lg[k]), avg_v[k], cyc == valid_at[k]);
                check($sformatf("n%0d_busy", lg[k]), busy_o[k],
                      (cyc >= busy_from[k]) && (cyc < free_at[k]));
                check($sformatf("n%0d_overrun", lg[k]), ovr_o[k], exp_ovr[k]);
                check($sformatf("n%0d_avg", lg[k]), avg_o[k],
                      {exp_avg[k][3], exp_avg[k][2], exp_avg[k][1], exp_avg[k][0]});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic check_zero(input string tag, input int k);
        check({tag, "_valid"}, avg_v[k], 1'b0);
        check({tag, "_busy"}, busy_o[k], 1'b0);
        check({tag, "_ovr"}, ovr_o[k], 1'b0);
        check({tag, "_avg"}, avg_o[k], '0);
        check({tag, "_state"}, st_o[k], ST_IDLE);
    endtask

    task automatic do_reset();
        _rst = 1'b0;
        data_ready = 1'b0;
        clr_ovr = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) check_zero("rst", k);
        step(3);
        _rst = 1'b1;
        step(2);
    endtask

    task automatic pulse(input int width, input int gap);
        data_ready = 1'b1;
        step(width);
        data_ready = 1'b0;
        step(gap);
    endtask

    task automatic rand_ch();
        for (int i = 0; i < 4; i++) ch[i] = 12'($urandom_range(0, 4095));
    endtask

    // ---------------- stimulus ----------------
    int v0 [3];

    task automatic snap_vcount();
        for (int k = 0; k < 3; k++) v0[k] = vcount[k];
    endtask

    initial begin
        _rst = 1'b0;
        data_ready = 1'b0;
        clr_ovr = 1'b0;
        for (int i = 0; i < 4; i++) ch[i] = '0;
        step(2);
        do_reset();

        // Four samples, LOG2N=2: ch0 ramps, ch3 at full scale.
        snap_vcount();
        for (int s = 0; s < 4; s++) begin
            rand_ch();
            ch[0] = 12'(100 * (s + 1));
            ch[3] = 12'd4095;
            pulse(1, 7);
        end
        check("n2_window_count", vcount[1] - v0[1], 1);
        check("n2_avg0_ramp", avg_o[1][0], 12'd250);
        check("n2_avg3_full", avg_o[1][3], 12'd4095);
        step(5);
        check("n2_avg0_hold", avg_o[1][0], 12'd250);

        // Eight samples, LOG2N=3: ch1 alternates 1,2 -> 12/8 truncates to 1.
        do_reset();
        snap_vcount();
        for (int s = 0; s < 8; s++) begin
            rand_ch();
            ch[1] = (s % 2 == 0) ? 12'd1 : 12'd2;
            pulse(1, 7);
        end
        check("n3_window_count", vcount[2] - v0[2], 1);
        check("n3_avg1_trunc", avg_o[2][1], 12'd1);

        // Second edge two cycles after the first is dropped.
        do_reset();
        snap_vcount();
        rand_ch();
        pulse(1, 1);
        rand_ch();
        pulse(1, 6);
        check("n2_ovr_set", ovr_o[1], 1'b1);
        clr_ovr = 1'b1;
        step(1);
        clr_ovr = 1'b0;
        step(1);
        check("n2_ovr_clr", ovr_o[1], 1'b0);
        for (int s = 0; s < 2; s++) begin
            rand_ch();
            pulse(1, 7);
        end
        check("n2_drop_extra_pending", vcount[1] - v0[1], 0);
        rand_ch();
        pulse(1, 7);
        check("n2_drop_extra_done", vcount[1] - v0[1], 1);

        // Reset in the second ACC cycle of the third sample, with state
        // (averages, overrun, busy) all non-zero beforehand.
        rand_ch();
        pulse(1, 1);
        rand_ch();
        pulse(1, 6);
        rand_ch();
        pulse(1, 7);
        rand_ch();
        data_ready = 1'b1;
        step(1);
        data_ready = 1'b0;
        step(1);
        _rst = 1'b0;
        #1;
        check_zero("midacc", 1);
        step(2);
        _rst = 1'b1;
        step(2);
        snap_vcount();
        for (int s = 0; s < 3; s++) begin
            rand_ch();
            pulse(1, 7);
        end
        check("n2_after_rst_3", vcount[1] - v0[1], 0);
        rand_ch();
        pulse(1, 7);
        check("n2_after_rst_4", vcount[1] - v0[1], 1);

        // data_ready high across reset release is not an event.
        _rst = 1'b0;
        data_ready = 1'b1;
        step(3);
        _rst = 1'b1;
        snap_vcount();
        step(10);
        check("rel_high_count", vcount[0] - v0[0], 0);
        check("rel_high_busy", busy_o[0], 1'b0);
        data_ready = 1'b0;
        step(2);

        // Level held high for 20 cycles: one event only.
        snap_vcount();
        rand_ch();
        ch[2] = 12'hABC;
        data_ready = 1'b1;
        step(20);
        data_ready = 1'b0;
        step(4);
        check("n0_level_count", vcount[0] - v0[0], 1);
        check("n0_level_avg2", avg_o[0][2], 12'hABC);

        // Edges spaced exactly six cycles: each lands on the IDLE return.
        do_reset();
        snap_vcount();
        for (int s = 0; s < 8; s++) begin
            rand_ch();
            pulse(1, 5);
        end
        step(2);
        check("n0_back2back_count", vcount[0] - v0[0], 8);
        check("n2_back2back_count", vcount[1] - v0[1], 2);
        check("n3_back2back_count", vcount[2] - v0[2], 1);
        for (int k = 0; k < 3; k++) check($sformatf("n%0d_back2back_ovr", lg[k]), ovr_o[k], 1'b0);

        // Random traffic with occasional clears and one mid-stream reset.
        do_reset();
        for (int s = 0; s < 200; s++) begin
            rand_ch();
            clr_ovr = ($urandom_range(0, 7) == 0);
            data_ready = 1'b1;
            step(1);
            rand_ch();
            if ($urandom_range(1, 3) > 1) step($urandom_range(1, 2));
            data_ready = 1'b0;
            step($urandom_range(1, 8));
            if (s == 100) begin
                _rst = 1'b0;
                step(2);
                _rst = 1'b1;
            end
        end
        clr_ovr = 1'b0;
        step(10);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_averager.md
ADC_AVERAGER -- requirements
Module: adc_averager

Interface
REQ-001 The block SHALL have parameter LOG2N, default 3, meaning log2 of the samples averaged per output (legal range 0..6).
REQ-002 Port clk, input, 1 bit, the single system clock; all state SHALL update on its rising edge.
REQ-003 Port _rst, input, 1 bit, asynchronous active-low reset.
REQ-004 Port data_ready, input, 1 bit, conversion-complete indication from the ADS7924 driver, pulse or level.
REQ-005 Ports ch0, ch1, ch2, ch3, input, 12 bits each, unsigned conversion results, valid when data_ready rises.
REQ-006 Port clr_ovr, input, 1 bit, synchronous clear of the overrun flag.
REQ-007 Ports avg0, avg1, avg2, avg3, output, 12 bits each, registered averaged results.
REQ-008 Port avg_valid, output, 1 bit, one-cycle strobe marking new avg0..avg3.
REQ-009 Port busy, output, 1 bit, high while accumulating or finishing.
REQ-010 Port overrun, output, 1 bit, sticky flag for a dropped sample.

Function
REQ-011 A sample event SHALL be a rising edge of data_ready: data_ready=1 in the current cycle and 0 in the previous cycle, using a registered copy.
REQ-012 In IDLE, a sample event in cycle T SHALL snapshot ch0..ch3 into 12-bit holding registers at the end of T and enter ACC.
REQ-013 The FSM SHALL have exactly these states: IDLE, ACC, DONE.
REQ-014 ACC SHALL last exactly 4 cycles, T+1..T+4, adding one channel per cycle in order 0,1,2,3 through a single shared adder into that channel's (12+LOG2N)-bit accumulator.
REQ-015 Accumulators SHALL never overflow, because the width rule covers 2^LOG2N x 4095.
REQ-016 A LOG2N-bit sample counter SHALL increment at the end of ACC.
REQ-017 If the sample counter was not at 2^LOG2N-1, the FSM SHALL leave ACC for IDLE.
REQ-018 If the sample counter was at 2^LOG2N-1, it SHALL wrap to 0 and the FSM SHALL leave ACC for DONE.
REQ-019 In DONE (cycle T+5), avgN SHALL load accN >> LOG2N, truncated, and all accumulators SHALL clear.
REQ-020 avg_valid SHALL be high for exactly cycle T+6, then return to IDLE.
REQ-021 With LOG2N=0, every sample SHALL produce avg_valid, with avgN equal to the snapshot.
REQ-022 avgN SHALL hold its value between avg_valid strobes.
REQ-023 busy SHALL be high in ACC and DONE and low in IDLE.
REQ-024 A sample event while busy SHALL be dropped: no snapshot, no counter change, overrun set.
REQ-025 overrun SHALL clear when clr_ovr=1.
REQ-026 If clr_ovr=1 coincides with a dropped sample, set SHALL win.
REQ-027 data_ready held high SHALL count as one event only.
REQ-028 A sample event in the cycle the FSM returns to IDLE SHALL be accepted.

Reset
REQ-029 _rst=0 SHALL asynchronously force IDLE and clear to 0: accumulators, sample counter, snapshots, avg0..avg3, avg_valid, busy, overrun, and the data_ready history register.
REQ-030 Reset mid-ACC SHALL discard the partial window.
REQ-031 After reset release, the first window SHALL need a full 2^LOG2N samples.
REQ-032 data_ready already high at reset release SHALL NOT be a sample event.

Structure
REQ-033 A shared package/include SHALL hold the FSM state encodings, the channel count (4) and the sample width (12), guarded against double inclusion.
REQ-034 One sub-module, adc_acc_lane (a per-channel accumulator with clear and add-enable), SHALL be instantiated four times.
REQ-035 The shared adder operand mux and the FSM SHALL stay in adc_averager.

Verification
REQ-036 LOG2N=2; four events with ch0=100,200,300,400 and ch3=4095 constant -> one avg_valid, six cycles after the fourth edge; avg0=250, avg3=4095.
REQ-037 LOG2N=3; eight events with ch1 alternating 1 and 2 -> avg1=1 (truncation of 12/8).
REQ-038 Second data_ready edge 2 cycles after the first -> sample dropped, overrun=1, window needs one extra sample; clr_ovr pulse then clears overrun.
REQ-039 _rst asserted in the 2nd ACC cycle of the 3rd sample, LOG2N=2 -> all outputs 0 immediately; next avg_valid only after 4 new samples.
REQ-040 LOG2N=0; data_ready held high 20 cycles with ch2=0xABC -> exactly one avg_valid, avg2=0xABC.
REQ-041 Event exactly at the IDLE return cycle after avg_valid -> accepted, overrun stays 0.
